// File: rtl/log2_hist.sv
// log2_hist: per-degree event histogram for the log2 stage.
// Eight saturating bin counters (one per degree) plus one reject counter, with a
// registered single-cycle read port and a sticky saturation flag.
module log2_hist #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       num,
    input  logic [2:0]       degree,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [3:0]       rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy_sat
);

    localparam int unsigned      NumCnt = 9;
    localparam logic [3:0]       RejIdx = 4'd8;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q [NumCnt];
    logic [CNT_W-1:0] cnt_d [NumCnt];
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic       is_pow2;
    logic       deg_match;
    logic [3:0] hit_idx;

    // Classify the operand: matching power of two goes to its bin, anything else to reject.
    always_comb begin
        is_pow2   = (num != 8'd0) && ((num & (num - 8'd1)) == 8'd0);
        deg_match = (num == (8'd1 << degree));
        hit_idx   = (is_pow2 && deg_match) ? {1'b0, degree} : RejIdx;
    end

    // Counter next state: clear wins over an event; a full counter holds and flags saturation.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear) begin
            cnt_d = '{default: '0};
            sat_d = 1'b0;
        end else if (in_valid) begin
            if (cnt_q[hit_idx] == CntMax) begin
                sat_d = 1'b1;
            end else begin
                cnt_d[hit_idx] = cnt_q[hit_idx] + 1'b1;
            end
        end
    end

    // Read next state: samples pre-edge counter state, so collisions return the old value.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = (rd_addr <= RejIdx) ? cnt_q[rd_addr] : '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '{default: '0};
            sat_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy_sat = sat_q;

endmodule

// File: doc/log2_hist.md
Name: log2_hist

Overview:
- Downstream consumer of the combinational log2 stage (num[7:0] -> degree[2:0]).
- Samples each valid (num, degree) pair and keeps eight saturating per-degree event counters plus one reject counter for inputs that are zero or not powers of two.
- Software or test logic reads the counters back through a registered read port.
- Used to profile the distribution of operand magnitudes that reach the log2 stage.

Parameters:
- CNT_W, 16, width of each histogram and reject counter (legal range 4..32)

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  qualifies num/degree this cycle
- num  in  8  operand presented to the log2 stage
- degree  in  3  log2 stage output for num
- clear  in  1  synchronous clear of all counters
- rd_en  in  1  read request
- rd_addr  in  4  0..7 = degree bins, 8 = reject counter, 9..15 = reserved
- rd_data  out  CNT_W  read result
- rd_valid  out  1  rd_data valid strobe
- busy_sat  out  1  sticky flag: some counter has saturated since the last clear/reset

Behaviour:
- Reset (rst_n low, asynchronous): all nine counters, rd_data, rd_valid and busy_sat go to 0 immediately, and stay 0 while rst_n is low.
- Classification is combinational on num. is_pow2 = (num != 0) && ((num & (num-1)) == 0).
- Accepted event: in_valid && is_pow2 && (num == (1 << degree)).
  - Next edge: bin[degree] += 1.
- Reject event: in_valid, and either not is_pow2 or a degree mismatch.
  - Next edge: reject counter += 1.
  - A mismatch means the log2 stage disagrees with num; it counts as a reject, never as a bin hit.
- in_valid low: no counter changes. num and degree are don't-care.
- At most one counter changes per cycle.
- Saturation:
  - A counter at 2^CNT_W-1 holds its value on a further event; it never wraps.
  - The same edge sets busy_sat = 1.
  - busy_sat stays 1 until clear or reset.
- clear high at an edge: all counters and busy_sat go to 0.
  - clear has priority over an in_valid event in the same cycle; that event is dropped.
  - clear does not affect rd_valid/rd_data timing.
- Read, 1-cycle latency:
  - rd_en at edge N -> rd_valid = 1 and rd_data = counter[rd_addr] after edge N, both held for exactly one cycle.
  - rd_valid = 0 in any cycle not preceded by rd_en.
  - rd_data holds its last value when rd_valid = 0.
  - Reserved addresses return 0 with rd_valid = 1.
- Read/update collision: rd_en to a counter that is updated at the same edge returns the pre-update value. Reads sample the counter state before the edge.
- Read/clear collision: rd_en together with clear returns the pre-clear value.
- Back-to-back reads are allowed every cycle, one result per cycle, in order.
- No flow control on in_valid: the block accepts one event per cycle unconditionally.

Test Plan:
- Reset then sweep: num = 1,2,4,...,128 with matching degree 0..7, one each, in_valid high; then read addr 0..8 -> each bin = 1, reject = 0, busy_sat = 0, rd_valid pulses one cycle after each rd_en.
- Rejects: in_valid with num = 0, 3, 255, and num = 8 with degree = 2 -> reject = 4, all bins = 0.
- Saturation with CNT_W = 4: 17 events of num = 16/degree = 4 -> bin4 = 15, busy_sat rises on the 16th event edge and stays 1; other counters 0.
- Collisions: bin2 = 5, then rd_en addr 2 with an accepted num = 4 event in the same cycle -> rd_data = 5; next read -> 6. Then clear with in_valid num = 4 and rd_en addr 2 -> rd_data = 6, and a following read -> 0.
- Async reset mid-operation: bins nonzero, rd_en pending, rst_n pulled low between edges -> counters, rd_valid, rd_data and busy_sat read 0 immediately; after release, reads of all addresses return 0; reserved addr 12 -> 0 with rd_valid = 1.
